// File: rtl/usr_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : usr_byte_packer
// Purpose  : Captures nibbles from the universal shift register, pairs
//            consecutive nibbles into bytes (first nibble = low half) and
//            buffers the bytes in a show-ahead FIFO drained by valid/ready.
//            The nibble input cannot stall, so a byte arriving at a full
//            FIFO is dropped and recorded in a sticky overflow flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: PACKER_PARITY_EN (adds dout_parity = ^dout)
// ----------------------------------------------------------------------------
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   nib_valid   in   nib_data carries a nibble this cycle
//   nib_data    in   [3:0] nibble from the shift register
//   flush       in   emit a held low nibble as {4'h0, low}
//   clr_ovf     in   clear sticky overflow (a same-cycle drop wins)
//   dout        out  [7:0] head-of-FIFO byte, 8'h00 when empty
//   dout_valid  out  FIFO non-empty
//   dout_ready  in   consumer accepts dout this cycle
//   count       out  [$clog2(DEPTH):0] bytes stored
//   pending     out  low nibble held, waiting for the high nibble
//   overflow    out  sticky: a completed byte was dropped
//   dout_parity out  (PACKER_PARITY_EN only) XOR of dout, 0 when empty
// ============================================================================
module usr_byte_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     nib_valid,
    input  logic [3:0]               nib_data,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic [7:0]               dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pending,
`ifdef PACKER_PARITY_EN
    output logic                     dout_parity,
`endif
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } state_t;

    state_t             r_state_q,  w_state_d;
    logic [3:0]         r_low_q,    w_low_d;
    logic [PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0]   r_count_q,  w_count_d;
    logic               r_ovf_q,    w_ovf_d;
    logic [7:0]         r_mem_q [DEPTH];

    logic               w_push_req;
    logic [7:0]         w_push_byte;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;

    // ------------------------------------------------------------------
    // Packer FSM: a completing nibble always takes priority over flush.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_low_d     = r_low_q;
        w_push_req  = 1'b0;
        w_push_byte = 8'h00;
        case (r_state_q)
            ST_IDLE: begin
                if (nib_valid) begin
                    w_low_d   = nib_data;
                    w_state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (nib_valid) begin
                    w_push_req  = 1'b1;
                    w_push_byte = {nib_data, r_low_q};
                    w_state_d   = ST_IDLE;
                end else if (flush) begin
                    w_push_req  = 1'b1;
                    w_push_byte = {4'h0, r_low_q};
                    w_state_d   = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control. A pop in the same cycle frees the slot a push into a
    // full FIFO needs, so the push is accepted in that case.
    // ------------------------------------------------------------------
    always_comb begin
        w_empty    = (r_count_q == '0);
        w_full     = (r_count_q == C_DEPTH);
        w_pop      = !w_empty && dout_ready;
        w_push_ok  = w_push_req && (!w_full || w_pop);

        w_wr_ptr_d = w_push_ok ? r_wr_ptr_q + PTR_W'(1) : r_wr_ptr_q;
        w_rd_ptr_d = w_pop     ? r_rd_ptr_q + PTR_W'(1) : r_rd_ptr_q;

        w_count_d  = r_count_q;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_d = r_count_q + CNT_W'(1);
            2'b01:   w_count_d = r_count_q - CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase

        // A refused push sets the flag even if clr_ovf is asserted.
        w_ovf_d = (r_ovf_q && !clr_ovf) || (w_push_req && !w_push_ok);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q  <= ST_IDLE;
            r_low_q    <= 4'h0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_low_q    <= w_low_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    // Storage is not reset; empty-state masking on dout keeps it clean.
    always_ff @(posedge clock) begin
        if (reset && w_push_ok) begin
            r_mem_q[r_wr_ptr_q] <= w_push_byte;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all from registered state)
    // ------------------------------------------------------------------
    assign dout       = w_empty ? 8'h00 : r_mem_q[r_rd_ptr_q];
    assign dout_valid = !w_empty;
    assign count      = r_count_q;
    assign pending    = (r_state_q == ST_HALF);
    assign overflow   = r_ovf_q;

`ifdef PACKER_PARITY_EN
    assign dout_parity = ^dout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usr_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usr_byte_packer
// Purpose  : Self-checking bench for usr_byte_packer. Directed scenarios
//            followed by random traffic, all compared every cycle against a
//            queue-based reference model of the packer and FIFO.
// Revision : 1.0 - initial release
// Optional feature macro: PACKER_PARITY_EN (parity output also checked)
// ============================================================================
module tb_usr_byte_packer;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       flush;
    logic       clr_ovf;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] count;
    logic       pending;
    logic       overflow;
`ifdef PACKER_PARITY_EN
    logic       dout_parity;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_pending;
    logic [3:0] m_low;
    bit         m_ovf;

    usr_byte_packer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .nib_valid  (nib_valid),
        .nib_data   (nib_data),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .pending    (pending),
`ifdef PACKER_PARITY_EN
        .dout_parity(dout_parity),
`endif
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_dout;
        exp_dout = (m_q.size() > 0) ? m_q[0] : 8'h00;
        chk({tag, ".dout"},     32'(dout),       32'(exp_dout));
        chk({tag, ".valid"},    32'(dout_valid), 32'(m_q.size() > 0));
        chk({tag, ".count"},    32'(count),      32'(m_q.size()));
        chk({tag, ".pending"},  32'(pending),    32'(m_pending));
        chk({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
`ifdef PACKER_PARITY_EN
        chk({tag, ".parity"},   32'(dout_parity), 32'($countones(exp_dout) % 2));
`endif
    endtask

    // One clock cycle with the given inputs; the model advances using the
    // values that were presented at the edge, then outputs are compared.
    task automatic cycle(input string tag, input bit nv, input logic [3:0] nd,
                         input bit fl, input bit clr, input bit rdy);
        bit         has_byte;
        bit         dropped;
        logic [7:0] b;
        nib_valid  = nv;
        nib_data   = nd;
        flush      = fl;
        clr_ovf    = clr;
        dout_ready = rdy;
        @(posedge clock);
        has_byte = 0;
        dropped  = 0;
        b        = 8'h00;
        if (m_pending) begin
            if (nv) begin
                b = {nd, m_low}; has_byte = 1; m_pending = 0;
            end else if (fl) begin
                b = {4'h0, m_low}; has_byte = 1; m_pending = 0;
            end
        end else if (nv) begin
            m_low = nd; m_pending = 1;
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (has_byte) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else dropped = 1;
        end
        m_ovf = (m_ovf && !clr) || dropped;
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        nib_valid = 0; nib_data = 4'h0; flush = 0; clr_ovf = 0; dout_ready = 0;
        @(posedge clock);
        m_q.delete();
        m_pending = 0;
        m_low = 4'h0;
        m_ovf = 0;
        #1;
        reset = 1'b1;
        check_model(tag);
    endtask

    initial begin
        logic [7:0] exp_drain [4];
        reset = 1'b1;
        nib_valid = 0; nib_data = 4'h0; flush = 0; clr_ovf = 0; dout_ready = 0;
        #2;

        // Reset state
        do_reset("reset");
        chk("reset.dout_const", 32'(dout), 32'h00);
        chk("reset.count_const", 32'(count), 0);

        // Basic pairing
        cycle("pair1", 1, 4'h3, 0, 0, 1);
        chk("pair1.pending_const", 32'(pending), 1);
        cycle("pair2", 1, 4'hA, 0, 0, 1);
        chk("pair.dout_const", 32'(dout), 32'hA3);
        chk("pair.valid_const", 32'(dout_valid), 1);
        cycle("pair3", 0, 4'h0, 0, 0, 1);
        chk("pair.count_zero", 32'(count), 0);

        // Flush of a half byte, then flush while idle
        cycle("flush1", 1, 4'h5, 0, 0, 0);
        cycle("flush2", 0, 4'h0, 1, 0, 0);
        chk("flush.dout_const", 32'(dout), 32'h05);
        cycle("flush3", 0, 4'h0, 0, 0, 1);
        cycle("flush_idle", 0, 4'h0, 1, 0, 0);
        chk("flush_idle.count", 32'(count), 0);

        // Flush coinciding with the completing nibble
        cycle("flc1", 1, 4'h1, 0, 0, 0);
        cycle("flc2", 1, 4'h2, 1, 0, 0);
        chk("flc.dout_const", 32'(dout), 32'h21);
        chk("flc.count_const", 32'(count), 1);
        chk("flc.pending_const", 32'(pending), 0);
        cycle("flc3", 0, 4'h0, 0, 0, 1);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 4; i++) begin
            cycle("fill_lo", 1, 4'(2 * i), 0, 0, 0);
            cycle("fill_hi", 1, 4'(2 * i + 1), 0, 0, 0);
        end
        chk("fill.count_const", 32'(count), 4);
        cycle("ovf_lo", 1, 4'h8, 0, 0, 0);
        cycle("ovf_hi", 1, 4'h9, 0, 0, 0);
        chk("ovf.flag_const", 32'(overflow), 1);
        chk("ovf.count_const", 32'(count), 4);
        exp_drain[0] = 8'h10; exp_drain[1] = 8'h32;
        exp_drain[2] = 8'h54; exp_drain[3] = 8'h76;
        for (int i = 0; i < 4; i++) begin
            chk("drain.order", 32'(dout), 32'(exp_drain[i]));
            cycle("drain", 0, 4'h0, 0, 0, 1);
        end
        chk("drain.empty", 32'(dout_valid), 0);
        cycle("clr_ovf", 0, 4'h0, 0, 1, 0);
        chk("clr_ovf.const", 32'(overflow), 0);

        // Full FIFO with a pop in the completing cycle
        for (int i = 0; i < 4; i++) begin
            cycle("full_lo", 1, 4'(2 * i), 0, 0, 0);
            cycle("full_hi", 1, 4'(2 * i + 1), 0, 0, 0);
        end
        cycle("fullpop_lo", 1, 4'hB, 0, 0, 0);
        cycle("fullpop_hi", 1, 4'hC, 0, 0, 1);
        chk("fullpop.count_const", 32'(count), 4);
        chk("fullpop.ovf_const", 32'(overflow), 0);
        for (int i = 0; i < 3; i++) cycle("fullpop_drain", 0, 4'h0, 0, 0, 1);
        chk("fullpop.last_const", 32'(dout), 32'hCB);
        cycle("fullpop_end", 0, 4'h0, 0, 0, 1);

        // Reset mid-operation: two bytes stored and a low nibble held
        cycle("mid_a", 1, 4'h1, 0, 0, 0);
        cycle("mid_b", 1, 4'h2, 0, 0, 0);
        cycle("mid_c", 1, 4'h3, 0, 0, 0);
        cycle("mid_d", 1, 4'h4, 0, 0, 0);
        cycle("mid_e", 1, 4'hF, 0, 0, 0);
        chk("mid.pending_const", 32'(pending), 1);
        chk("mid.count_const", 32'(count), 2);
        do_reset("mid_reset");
        chk("mid_reset.count_const", 32'(count), 0);
        chk("mid_reset.pending_const", 32'(pending), 0);
        cycle("post_lo", 1, 4'h7, 0, 0, 0);
        cycle("post_hi", 1, 4'h6, 0, 0, 0);
        chk("post.dout_const", 32'(dout), 32'h67);
`ifdef PACKER_PARITY_EN
        chk("post.parity_const", 32'(dout_parity), 1);
`endif
        cycle("post_drain", 0, 4'h0, 0, 0, 1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  bit'($urandom_range(0, 3) != 0),
                  4'($urandom),
                  bit'($urandom_range(0, 3) == 0),
                  bit'($urandom_range(0, 7) == 0),
                  bit'($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
        end

        // Sustained input with ready held high never overflows
        do_reset("sustain_reset");
        for (int i = 0; i < 40; i++) cycle("sustain", 1, 4'($urandom), 0, 0, 1);
        chk("sustain.no_ovf", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
